// File: rtl/cache_types_pkg.sv
// Shared types and sizing for the L2 line <-> memory burst adaptor.
package cache_types_pkg;
    localparam int S_LINE  = 256;
    localparam int S_BURST = 64;
    localparam int BEATS   = S_LINE / S_BURST;
    localparam int CNT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit L2 line reads/writebacks into four-beat 64-bit memory bursts,
// one transaction at a time, with all outputs decoded from registered state.
module cacheline_adaptor
    import cache_types_pkg::*;
#(
    parameter int s_line   = S_LINE,
    parameter int s_burst  = S_BURST,
    parameter int s_offset = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);
    localparam logic [31:0]      ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);

    adaptor_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [s_line-1:0] line_q, line_d;
    logic [31:0]       addr_q, addr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            line_q <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                // Read has priority when L2 raises both requests together.
                if (read_i) begin
                    addr_d  = address_i & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = READ;
                end else if (write_i) begin
                    addr_d  = address_i & ALIGN_MASK;
                    cnt_d   = '0;
                    line_d  = line_i;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (resp_i) begin
                    line_d[cnt_q*s_burst +: s_burst] = burst_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_o    = (state_q == READ);
    assign write_o   = (state_q == WRITE);
    assign resp_o    = (state_q == DONE);
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = line_q[cnt_q*s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reset, reads, gapped writes, priority, stray acks.
module tb_cacheline_adaptor;
    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int total = 0;
    int bad   = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got rd/wr/resp=%b want 000", {read_o, write_o, resp_o});
        end
        total++;
        if (line_o !== 256'h0) begin
            bad++;
            $display("FAIL reset_line: got %h want 0", line_o);
        end
        total++;
        if (address_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h want 0", address_o);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read_b2b();
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = {16{4'h1}};
        b[1] = {16{4'h2}};
        b[2] = {16{4'h3}};
        b[3] = {16{4'h4}};
        exp_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        address_i = 32'h0000_1234;
        read_i = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({read_o, write_o, resp_o} !== 3'b100 || address_o !== 32'h0000_1220) begin
                bad++;
                $display("FAIL rd_active[%0d]: got rd/wr/resp=%b addr=%h want 100 addr=00001220",
                         k, {read_o, write_o, resp_o}, address_o);
            end
            resp_i  = 1'b1;
            burst_i = b[k];
            tick();
        end
        total++;
        if ({read_o, resp_o} !== 2'b01) begin
            bad++;
            $display("FAIL rd_done_cycle5: got rd/resp=%b want 01", {read_o, resp_o});
        end
        total++;
        if (line_o !== exp_line) begin
            bad++;
            $display("FAIL rd_line: got %h want %h", line_o, exp_line);
        end
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== exp_line) begin
            bad++;
            $display("FAIL rd_after: got rd/wr/resp=%b line=%h want 000 line=%h",
                     {read_o, write_o, resp_o}, line_o, exp_line);
        end
    endtask

    task automatic test_write_gaps();
        logic [63:0] d [4];
        logic [6:0]  pat;
        int          idx;
        d[0] = 64'hD0D0_0000_0000_00D0;
        d[1] = 64'hD1D1_1111_1111_11D1;
        d[2] = 64'hD2D2_2222_2222_22D2;
        d[3] = 64'hD3D3_3333_3333_33D3;
        pat  = 7'b1100101;
        line_i    = {d[3], d[2], d[1], d[0]};
        address_i = 32'hABCD_EF7F;
        write_i   = 1'b1;
        tick();
        total++;
        if (address_o !== 32'hABCD_EF60) begin
            bad++;
            $display("FAIL wr_addr: got %h want abcdef60", address_o);
        end
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            total++;
            if ({read_o, write_o, resp_o} !== 3'b010 || burst_o !== d[idx]) begin
                bad++;
                $display("FAIL wr_beat[%0d]: got rd/wr/resp=%b burst=%h want 010 burst=%h",
                         k, {read_o, write_o, resp_o}, burst_o, d[idx]);
            end
            resp_i = pat[k];
            tick();
            if (pat[k]) idx++;
        end
        total++;
        if ({write_o, resp_o} !== 2'b01) begin
            bad++;
            $display("FAIL wr_done: got wr/resp=%b want 01", {write_o, resp_o});
        end
        write_i = 1'b0;
        resp_i  = 1'b0;
        tick();
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000) begin
            bad++;
            $display("FAIL wr_after: got rd/wr/resp=%b want 000", {read_o, write_o, resp_o});
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = 64'h5555_5555_5555_5555;
        b[1] = 64'h6666_6666_6666_6666;
        b[2] = 64'h7777_7777_7777_7777;
        b[3] = 64'h8888_8888_8888_8888;
        exp_line  = {b[3], b[2], b[1], b[0]};
        line_i    = {256{1'b1}};
        address_i = 32'h0000_0040;
        read_i    = 1'b1;
        write_i   = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({read_o, write_o} !== 2'b10) begin
                bad++;
                $display("FAIL both_beat[%0d]: got rd/wr=%b want 10", k, {read_o, write_o});
            end
            resp_i  = 1'b1;
            burst_i = b[k];
            tick();
        end
        total++;
        if ({read_o, write_o, resp_o} !== 3'b001 || line_o !== exp_line) begin
            bad++;
            $display("FAIL both_done: got rd/wr/resp=%b line=%h want 001 line=%h",
                     {read_o, write_o, resp_o}, line_o, exp_line);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        tick();
    endtask

    task automatic test_stray_acks();
        logic [63:0]  b [4];
        logic [63:0]  w [4];
        logic [255:0] prev_line;
        logic [255:0] exp_line;
        int           pulses;
        prev_line = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                     64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        b[0] = 64'hA0A0_A0A0_A0A0_A0A0;
        b[1] = 64'hA1A1_A1A1_A1A1_A1A1;
        b[2] = 64'hA2A2_A2A2_A2A2_A2A2;
        b[3] = 64'hA3A3_A3A3_A3A3_A3A3;
        w[0] = 64'hC0C0_0000_0000_0001;
        w[1] = 64'hC1C1_0000_0000_0002;
        w[2] = 64'hC2C2_0000_0000_0003;
        w[3] = 64'hC3C3_0000_0000_0004;
        exp_line = {b[3], b[2], b[1], b[0]};
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== prev_line) begin
                bad++;
                $display("FAIL stray_idle[%0d]: got rd/wr/resp=%b line=%h want 000 line=%h",
                         k, {read_o, write_o, resp_o}, line_o, prev_line);
            end
        end
        pulses    = 0;
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            burst_i = b[k];
            tick();
            if (resp_o === 1'b1) pulses++;
        end
        total++;
        if (line_o !== exp_line) begin
            bad++;
            $display("FAIL stray_rd_line: got %h want %h", line_o, exp_line);
        end
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
        if (resp_o === 1'b1) pulses++;
        line_i    = {w[3], w[2], w[1], w[0]};
        address_i = 32'h0000_3000;
        write_i   = 1'b1;
        tick();
        if (resp_o === 1'b1) pulses++;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (write_o !== 1'b1 || burst_o !== w[k]) begin
                bad++;
                $display("FAIL b2b_wr_beat[%0d]: got wr=%b burst=%h want 1 burst=%h",
                         k, write_o, burst_o, w[k]);
            end
            resp_i = 1'b1;
            tick();
            if (resp_o === 1'b1) pulses++;
        end
        write_i = 1'b0;
        resp_i  = 1'b0;
        tick();
        if (resp_o === 1'b1) pulses++;
        total++;
        if (pulses !== 2) begin
            bad++;
            $display("FAIL b2b_resp_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0]  b [4];
        logic [255:0] exp_line;
        b[0] = 64'h0101_0101_0101_0101;
        b[1] = 64'h0202_0202_0202_0202;
        b[2] = 64'h0303_0303_0303_0303;
        b[3] = 64'h0404_0404_0404_0404;
        exp_line  = {b[3], b[2], b[1], b[0]};
        address_i = 32'h8000_00FF;
        read_i    = 1'b1;
        tick();
        resp_i  = 1'b1;
        burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
        tick();
        burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== 256'h0 || address_o !== 32'h0) begin
            bad++;
            $display("FAIL midrst_clear: got rd/wr/resp=%b line=%h addr=%h want 000 line=0 addr=0",
                     {read_o, write_o, resp_o}, line_o, address_o);
        end
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        address_i = 32'h0000_4567;
        read_i    = 1'b1;
        tick();
        total++;
        if (read_o !== 1'b1 || address_o !== 32'h0000_4560) begin
            bad++;
            $display("FAIL midrst_new_req: got rd=%b addr=%h want 1 addr=00004560", read_o, address_o);
        end
        for (int k = 0; k < 4; k++) begin
            resp_i  = 1'b1;
            burst_i = b[k];
            tick();
        end
        total++;
        if (resp_o !== 1'b1 || line_o !== exp_line) begin
            bad++;
            $display("FAIL midrst_refill: got resp=%b line=%h want 1 line=%h", resp_o, line_o, exp_line);
        end
        read_i = 1'b0;
        resp_i = 1'b0;
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        test_reset();
        test_read_b2b();
        test_write_gaps();
        test_simultaneous();
        test_stray_acks();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the L2 cache's 256-bit line interface to the 64-bit burst physical-memory port. Converts each line read into a four-beat burst read, and each line writeback into a four-beat burst write. Sits directly downstream of the L2 cache, between its pmem_* port and main memory. Serves one transaction at a time, with no queuing.

## Interface
Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory beat width in bits; number of beats = s_line/s_burst = 4.
- s_offset, 5, number of line-offset address bits, forced to zero on the memory address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low. Asserted (0) clears all state immediately.
- line_i  in  s_line  writeback data from L2 (pmem_wdata).
- line_o  out  s_line  assembled fill line to L2 (pmem_rdata).
- address_i  in  32  line address from L2.
- read_i  in  1  line read request.
- write_i  in  1  line write request.
- resp_o  out  1  one-cycle completion pulse to L2.
- burst_i  in  s_burst  read beat from memory.
- burst_o  out  s_burst  write beat to memory.
- address_o  out  32  {address_i[31:s_offset], s_offset'b0}, latched at acceptance.
- read_o  out  1  burst read active.
- write_o  out  1  burst write active.
- resp_i  in  1  memory beat acknowledge; one beat per cycle in which resp_i=1.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_o = write_o = resp_o = 0.
  - Requests are sampled only in IDLE.
  - read_i=1: latch the aligned address, clear the beat counter (2 bits), go to READ.
  - write_i=1 (and read_i=0): also latch line_i into the line buffer, then go to WRITE.
  - Both asserted: read wins; write_i is ignored for that cycle.
- READ:
  - read_o=1 and address_o is held stable.
  - Each cycle with resp_i=1: burst_i goes into buffer slice [64·cnt +: 64] and cnt increments.
  - The cycle that captures beat 3 transitions to DONE.
- WRITE:
  - write_o=1 and burst_o = buffer slice [64·cnt +: 64].
  - Each resp_i=1 advances cnt; after beat 3 go to DONE.
- DONE: resp_o=1 for exactly one cycle, then return to IDLE.
- line_o is driven from the line buffer at all times. It holds the last filled line until the next transaction is accepted.
- resp_i in IDLE or DONE is ignored and must not alter cnt or the buffer.
- Beats may arrive with gaps (resp_i=0 cycles); the counter simply holds.
- L2 must hold read_i/write_i and address_i stable until resp_o, and drop them in the cycle after resp_o. A request still high in the IDLE cycle after DONE starts a new transaction.
- Reset, including mid-burst:
  - state goes to IDLE; cnt, buffer and latched address clear to 0.
  - read_o, write_o and resp_o go to 0.
  - The partially transferred line is discarded.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Request seen at edge E0 → read_o/write_o high from E0 through the edge that captures beat 3.
- Memory answering immediately (resp_i high for 4 consecutive cycles starting the cycle after E0) → resp_o high in the 5th cycle after the request cycle. This is the minimum latency of 6 cycles, request to resp_o inclusive.
- read_o/write_o drop in the same cycle resp_o rises (DONE).
- line_o is valid no later than the resp_o cycle and stays stable afterwards.

## Structure
- Shared package cache_types_pkg holds:
  - adaptor_state_t enum {IDLE, READ, WRITE, DONE};
  - localparam BEATS = s_line/s_burst;
  - localparam CNT_W = $clog2(BEATS).
- Single module. The beat counter and line buffer are inline, and no sub-module is warranted.

## Test plan
- Reset (apply rst=0 in any state):
  - Stimulus: rst=0.
  - Required: read_o=write_o=resp_o=0, line_o=0, address_o=0.
- Read, back-to-back beats:
  - Stimulus: address_i=0x0000_1234; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - Required: address_o=0x0000_1220; line_o = {44..,33..,22..,11..}; one resp_o pulse in cycle 5 after the request.
- Write with gaps:
  - Stimulus: line_i = {D3,D2,D1,D0}; resp_i pattern 1,0,1,0,0,1,1.
  - Required: burst_o presents D0,D1,D2,D3 in order, each held until acked; resp_o pulses once after the final ack.
- Simultaneous read_i and write_i:
  - Required: read burst only; write_o never asserts.
- Stray and extra acks:
  - resp_i pulses in IDLE leave the next read's data in the correct slice order.
  - Back-to-back read then write with one IDLE cycle between them completes both, each with a single resp_o.
- Reset mid-read:
  - Stimulus: rst=0 after 2 beats.
  - Required: immediate IDLE with cleared outputs; a new read afterwards fills all four beats correctly from cnt=0.
